// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: responder FSM states, bus width defaults, memory-op encoding
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_t;

    // Encoded as {r_en, w_en}; control_unit uses the same mapping
    typedef enum logic [1:0] {
        MEM_NOP      = 2'b00,
        MEM_STORE    = 2'b01,
        MEM_LOAD     = 2'b10,
        MEM_CONFLICT = 2'b11
    } mem_op_t;

    function automatic mem_op_t mem_op(input logic r_en, input logic w_en);
        return mem_op_t'({r_en, w_en});
    endfunction

endpackage

// File: rtl/dm_storage.sv
// rtl/dm_storage.sv - DEPTH x DATA_W data RAM, one synchronous write port and one synchronous read port
module dm_storage #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data-memory responder: request latch, wait states, checked RAM access, ack
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ack,
    output logic              mem_err,
    output logic              mem_busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dm_state_t         state, state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    mem_op_t           op_q;
    logic              err_q;
    logic              load_q;
    logic [DATA_W-1:0] read_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              in_range;
    logic              access;
    logic              do_write;
    logic              do_read;
    logic              access_err;

    // One extra bit so DEPTH == 2**ADDR_W compares correctly without wrapping
    assign in_range   = {1'b0, addr_q} < (ADDR_W+1)'(DEPTH);
    assign access     = (state == ST_WAIT) && (cnt == 4'd0);
    assign do_write   = access && (op_q == MEM_STORE) && in_range;
    assign do_read    = access && (op_q == MEM_LOAD) && in_range;
    assign access_err = (op_q == MEM_CONFLICT) ||
                        (((op_q == MEM_LOAD) || (op_q == MEM_STORE)) && !in_range);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mem_req) state_nxt = ST_WAIT;
            ST_WAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= MEM_NOP;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            read_q  <= '0;
        end else begin
            if ((state == ST_IDLE) && mem_req) begin
                addr_q  <= data_address;
                wdata_q <= write_data;
                op_q    <= mem_op(mem_r_en, mem_w_en);
                cnt     <= 4'(WAIT_STATES);
            end
            if ((state == ST_WAIT) && (cnt != 4'd0))
                cnt <= cnt - 4'd1;
            if (access) begin
                err_q  <= access_err;
                load_q <= do_read;
            end
            if ((state == ST_RESP) && load_q)
                read_q <= ram_rdata;
        end
    end

    // RAM read data appears in the ack cycle; read_q keeps it afterwards
    assign mem_ack   = (state == ST_RESP);
    assign mem_err   = mem_ack && err_q;
    assign mem_busy  = (state != ST_IDLE);
    assign read_data = (mem_ack && load_q) ? ram_rdata : read_q;

    dm_storage #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) u_storage (
        .clk    (clk),
        .wr_en  (do_write),
        .wr_addr(addr_q[IDX_W-1:0]),
        .wr_data(wdata_q),
        .rd_en  (do_read),
        .rd_addr(addr_q[IDX_W-1:0]),
        .rd_data(ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int WIN = 10;

    logic       clk = 1'b0;
    logic       rst   [3];
    logic       req   [3];
    logic       r_en  [3];
    logic       w_en  [3];
    logic [7:0] addr  [3];
    logic [7:0] wdata [3];
    logic [7:0] rdata [3];
    logic       ack   [3];
    logic       err   [3];
    logic       busy  [3];

    int tests  = 0;
    int failed = 0;

    int         lat, nack, nbusy;
    logic       e;
    logic [7:0] rd;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(2)) dut_a (
        .clk(clk), .reset(rst[0]), .mem_req(req[0]), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
        .data_address(addr[0]), .write_data(wdata[0]), .read_data(rdata[0]),
        .mem_ack(ack[0]), .mem_err(err[0]), .mem_busy(busy[0]));

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(rst[1]), .mem_req(req[1]), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
        .data_address(addr[1]), .write_data(wdata[1]), .read_data(rdata[1]),
        .mem_ack(ack[1]), .mem_err(err[1]), .mem_busy(busy[1]));

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_STATES(2)) dut_c (
        .clk(clk), .reset(rst[2]), .mem_req(req[2]), .mem_r_en(r_en[2]), .mem_w_en(w_en[2]),
        .data_address(addr[2]), .write_data(wdata[2]), .read_data(rdata[2]),
        .mem_ack(ack[2]), .mem_err(err[2]), .mem_busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request on DUT d; inputs are scrambled after the accept edge. A second
    // request is pulsed at cycle rep_k (0 = none) to probe the busy-ignore rule.
    task automatic xfer(input int d, input logic r, input logic w,
                        input logic [7:0] a, input logic [7:0] wd,
                        input int rep_k, input logic [7:0] rep_a, input logic [7:0] rep_wd,
                        output int o_lat, output int o_nack, output int o_nbusy,
                        output logic o_err, output logic [7:0] o_rd);
        o_lat = -1; o_nack = 0; o_nbusy = 0; o_err = 1'b0; o_rd = 8'h00;
        @(negedge clk);
        req[d] = 1'b1; r_en[d] = r; w_en[d] = w; addr[d] = a; wdata[d] = wd;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (ack[d]) begin
                o_nack++;
                if (o_lat < 0) begin
                    o_lat = k; o_err = err[d]; o_rd = rdata[d];
                end
            end
            if (busy[d]) o_nbusy++;
            if (k == rep_k) begin
                req[d] = 1'b1; r_en[d] = 1'b0; w_en[d] = 1'b1; addr[d] = rep_a; wdata[d] = rep_wd;
            end else begin
                req[d] = 1'b0; r_en[d] = ~r; w_en[d] = ~w; addr[d] = ~a; wdata[d] = ~wd;
            end
        end
        req[d] = 1'b0; r_en[d] = 1'b0; w_en[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; r_en[d] = 1'b0; w_en[d] = 1'b0;
            addr[d] = 8'h00; wdata[d] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_rdata_%0d", d), 32'(rdata[d]), 32'h0);
            check($sformatf("reset_ack_%0d", d), 32'(ack[d]), 32'h0);
            check($sformatf("reset_err_%0d", d), 32'(err[d]), 32'h0);
            check($sformatf("reset_busy_%0d", d), 32'(busy[d]), 32'h0);
            rst[d] = 1'b0;
        end

        // Store A5 to 0x10, W=2
        xfer(0, 1'b0, 1'b1, 8'h10, 8'hA5, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_nack", 32'(nack), 32'd1);
        check("t1_busy_cycles", 32'(nbusy), 32'd4);
        check("t1_err", 32'(e), 32'h0);
        check("t1_rdata_unchanged", 32'(rd), 32'h00);

        // Load 0x10, value held afterwards, including across a store
        xfer(0, 1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t2_latency", 32'(lat), 32'd4);
        check("t2_rdata_at_ack", 32'(rd), 32'hA5);
        check("t2_err", 32'(e), 32'h0);
        check("t2_rdata_hold", 32'(rdata[0]), 32'hA5);
        xfer(0, 1'b0, 1'b1, 8'h11, 8'h42, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t2_rdata_after_store", 32'(rdata[0]), 32'hA5);

        // r_en and w_en both set
        xfer(0, 1'b1, 1'b1, 8'h10, 8'h5A, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t3_latency", 32'(lat), 32'd4);
        check("t3_err", 32'(e), 32'h1);
        check("t3_rdata_unchanged", 32'(rd), 32'hA5);
        xfer(0, 1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t3_ram_unchanged", 32'(rd), 32'hA5);
        xfer(0, 1'b1, 1'b0, 8'h11, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t3_load_11", 32'(rd), 32'h42);

        // Neither enable: acked no-op
        xfer(0, 1'b0, 1'b0, 8'h10, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("nop_latency", 32'(lat), 32'd4);
        check("nop_err", 32'(e), 32'h0);
        check("nop_rdata", 32'(rd), 32'h42);

        // Re-pulse during WAIT (W=2)
        xfer(0, 1'b0, 1'b1, 8'h30, 8'h77, 2, 8'h30, 8'h99, lat, nack, nbusy, e, rd);
        check("t4a_nack", 32'(nack), 32'd1);
        check("t4a_latency", 32'(lat), 32'd4);
        xfer(0, 1'b1, 1'b0, 8'h30, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t4a_load_30", 32'(rd), 32'h77);

        // W=0: latency 2, re-pulse ignored
        xfer(1, 1'b0, 1'b1, 8'h21, 8'h11, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t4b_latency", 32'(lat), 32'd2);
        check("t4b_busy_cycles", 32'(nbusy), 32'd2);
        xfer(1, 1'b0, 1'b1, 8'h20, 8'h77, 1, 8'h21, 8'h99, lat, nack, nbusy, e, rd);
        check("t4b_nack", 32'(nack), 32'd1);
        check("t4b_latency_rep", 32'(lat), 32'd2);
        xfer(1, 1'b1, 1'b0, 8'h21, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t4b_load_21", 32'(rd), 32'h11);
        xfer(1, 1'b1, 1'b0, 8'h20, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t4b_load_20", 32'(rd), 32'h77);

        // Store 3C aborted by reset in WAIT
        @(negedge clk);
        req[0] = 1'b1; r_en[0] = 1'b0; w_en[0] = 1'b1; addr[0] = 8'h10; wdata[0] = 8'h3C;
        @(negedge clk);
        req[0] = 1'b0; w_en[0] = 1'b0;
        check("t5_busy_before_reset", 32'(busy[0]), 32'h1);
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check("t5_busy", 32'(busy[0]), 32'h0);
        check("t5_ack", 32'(ack[0]), 32'h0);
        check("t5_err", 32'(err[0]), 32'h0);
        check("t5_rdata", 32'(rdata[0]), 32'h0);
        @(negedge clk);
        rst[0] = 1'b0;
        nack = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack[0]) nack++;
        end
        check("t5_no_ack", 32'(nack), 32'd0);
        xfer(0, 1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t5_old_contents", 32'(rd), 32'hA5);

        // DEPTH=16 range checks
        xfer(2, 1'b0, 1'b1, 8'h00, 8'hC0, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t6_store_0_err", 32'(e), 32'h0);
        xfer(2, 1'b0, 1'b1, 8'h0F, 8'hCF, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t6_store_15_err", 32'(e), 32'h0);
        xfer(2, 1'b0, 1'b1, 8'h20, 8'hEE, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t6_store_20_latency", 32'(lat), 32'd4);
        check("t6_store_20_err", 32'(e), 32'h1);
        xfer(2, 1'b0, 1'b1, 8'h10, 8'hDD, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t6_store_16_err", 32'(e), 32'h1);
        xfer(2, 1'b1, 1'b0, 8'h0F, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t6_load_15", 32'(rd), 32'hCF);
        check("t6_load_15_err", 32'(e), 32'h0);
        xfer(2, 1'b1, 1'b0, 8'h00, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t6_load_0", 32'(rd), 32'hC0);
        xfer(2, 1'b1, 1'b0, 8'h20, 8'h00, 0, 8'h00, 8'h00, lat, nack, nbusy, e, rd);
        check("t6_load_20_err", 32'(e), 32'h1);
        check("t6_load_20_rdata", 32'(rd), 32'hC0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
